// File: rtl/int_priority_ctrl.sv
// Four-source prioritised interrupt controller with per-source masking, a global enable
// and in-service nesting. Source 3 has the highest priority and may preempt lower ones.
module int_priority_ctrl #(
  parameter bit EDGE_TRIG = 1'b1,
  parameter bit IE_RESET  = 1'b0
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic [3:0] in_irq,
  input  logic [3:0] in_mask,
  input  logic       in_ie_set,
  input  logic       in_ie_clr,
  input  logic       in_ack,
  input  logic       in_eret,
  output logic       out_int_req,
  output logic [1:0] out_code,
  output logic       out_ie,
  output logic [3:0] out_pend,
  output logic [3:0] out_isr
);

  // Handshake: out_int_req/out_code act as "valid"; in_ack is the CPU taking it. The ack
  // only counts in a cycle where out_int_req is already high and no eret is present;
  // otherwise it is ignored and the request stays up.

  logic [3:0] irq_q;
  logic [3:0] rise;
  logic       ack_ok;
  logic [3:0] ack_hot;
  logic [3:0] top_hot;
  logic [3:0] pend_next;
  logic [3:0] isr_next;
  logic       ie_next;
  logic [3:0] allowed;
  logic [3:0] eligible;
  logic       req_next;
  logic [1:0] code_next;

  always_comb begin
    rise    = in_irq & ~irq_q;
    ack_ok  = in_ack & out_int_req & ~in_eret;
    ack_hot = '0;
    if (ack_ok) ack_hot[out_code] = 1'b1;

    if (EDGE_TRIG) pend_next = rise | (out_pend & ~ack_hot);
    else           pend_next = in_irq;

    top_hot = '0;
    for (int i = 0; i < 4; i++) begin
      if (out_isr[i]) top_hot = 4'(1 << i);
    end

    // eret retires the innermost (highest) handler; ack_hot is empty whenever eret is present
    isr_next = out_isr;
    if (in_eret) isr_next = isr_next & ~top_hot;
    isr_next = isr_next | ack_hot;

    if (in_ie_clr || ack_ok) ie_next = 1'b0;
    else if (in_ie_set)      ie_next = 1'b1;
    else                     ie_next = out_ie;

    // A source may request only if no in-service source sits at or above it
    allowed = '0;
    for (int i = 0; i < 4; i++) begin
      allowed[i] = ~|(isr_next >> i);
    end
    eligible = pend_next & ~in_mask & {4{ie_next}} & allowed;

    req_next  = |eligible;
    code_next = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (eligible[i]) code_next = 2'(i);
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      irq_q       <= '0;
      out_pend    <= '0;
      out_isr     <= '0;
      out_int_req <= 1'b0;
      out_code    <= 2'b00;
      out_ie      <= IE_RESET;
    end else begin
      irq_q       <= in_irq;
      out_pend    <= pend_next;
      out_isr     <= isr_next;
      out_int_req <= req_next;
      out_code    <= code_next;
      out_ie      <= ie_next;
    end
  end

endmodule
